// File: rtl/fastreadout_pkg.sv
// Shared sizes, pad bit indices and the FIFO request/response structs used by
// the fastreadout capture buffer.
package fastreadout_pkg;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam int WR_EN = 0;
  localparam int RD_EN = 1;
  localparam int CLR   = 2;
  localparam int VALID = 4;
  localparam int FULL  = 5;
  localparam int EMPTY = 6;
  localparam int OVF   = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  typedef struct packed {
    logic             clr;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] data;
  } fifo_req_t;

  typedef struct packed {
    logic             rd_fire;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;
    logic             ovf;
  } fifo_rsp_t;
endpackage

// File: rtl/fastreadout_fifo.sv
// Circular sample buffer: storage, pointers, occupancy count and sticky
// overflow. Reads and writes are only acted on while ena is high.
module fastreadout_fifo
  import fastreadout_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      ena,
  input  fifo_req_t req,
  output fifo_rsp_t rsp
);
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              full;
  logic              empty;
  logic              do_rd;
  logic              do_wr;
  logic              drop;
  logic              act;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign act   = ena & ~req.clr;
  assign do_rd = req.rd & ~empty;
  // A same-cycle read frees the slot, so a write into a full buffer still lands.
  assign do_wr = req.wr & (~full | do_rd);
  assign drop  = req.wr & full & ~do_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (ena) begin
      if (req.clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + 1'b1;
        if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        if (drop) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && act && do_wr) mem[wr_ptr] <= req.data;
  end

  assign rsp.rd_fire = act & do_rd;
  assign rsp.head    = mem[rd_ptr];
  assign rsp.full    = full;
  assign rsp.empty   = empty;
  assign rsp.ovf     = ovf;
endmodule

// File: rtl/fastreadout.sv
// TinyTapeout-facing top: maps pads onto the capture FIFO and registers the
// readout byte plus its one-cycle valid pulse.
module fastreadout
  import fastreadout_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  fifo_req_t        req;
  fifo_rsp_t        rsp;
  logic [WIDTH-1:0] rd_q;
  logic             vld_q;
  logic             unused_uio;

  assign req.clr  = uio_in[CLR];
  assign req.wr   = uio_in[WR_EN];
  assign req.rd   = uio_in[RD_EN];
  assign req.data = ui_in;
  assign unused_uio = ^uio_in[7:3];

  fastreadout_fifo u_fifo (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .req (req),
    .rsp (rsp)
  );

  // uo_out keeps the last byte read; valid only marks the cycle it changed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else if (ena) begin
      if (req.clr) begin
        rd_q  <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= rsp.rd_fire;
        if (rsp.rd_fire) rd_q <= rsp.head;
      end
    end
  end

  always_comb begin
    uio_out        = '0;
    uio_out[VALID] = vld_q;
    uio_out[FULL]  = rsp.full;
    uio_out[EMPTY] = rsp.empty;
    uio_out[OVF]   = rsp.ovf;
  end

  assign uo_out = rd_q;
  assign uio_oe = UIO_OE_VAL;
endmodule

// File: tb/tb_fastreadout.sv
// Directed bench for fastreadout: queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_fastreadout;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  fastreadout dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Reference model: the buffer is just a queue of bytes.
  logic [7:0] q[$];
  logic [7:0] m_uo  = '0;
  logic       m_vld = 1'b0;
  logic       m_ovf = 1'b0;

  always @(posedge clk) begin
    logic rd, wr;
    if (rst || (ena && uio_in[2])) begin
      q.delete();
      m_uo = '0; m_vld = 1'b0; m_ovf = 1'b0;
    end else if (ena) begin
      rd = uio_in[1] && (q.size() > 0);
      wr = uio_in[0] && ((q.size() < 16) || rd);
      if (uio_in[0] && !wr) m_ovf = 1'b1;
      if (rd) m_uo = q.pop_front();
      m_vld = rd;
      if (wr) q.push_back(ui_in);
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_uio;
    exp_uio = {m_ovf, q.size() == 0, q.size() == 16, m_vld, 4'b0000};
    checks++;
    if (uo_out !== m_uo) begin
      errors++;
      $display("FAIL model_uo_out t=%0t got %h want %h", $time, uo_out, m_uo);
    end
    checks++;
    if (uio_out !== exp_uio) begin
      errors++;
      $display("FAIL model_uio_out t=%0t got %h want %h", $time, uio_out, exp_uio);
    end
    checks++;
    if (uio_oe !== 8'hF0) begin
      errors++;
      $display("FAIL uio_oe t=%0t got %h want f0", $time, uio_oe);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Apply one cycle of control, then return 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    uio_in = {5'b0, c, r, w};
    ui_in  = d;
    @(posedge clk);
    #1;
    uio_in = '0;
  endtask

  initial begin
    @(posedge clk); #1;
    step(0, 0, 0, 8'h00);
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio", uio_out, 8'h40);
    check("reset_oe", uio_oe, 8'hF0);
    rst = 1'b0;

    // Basic write then read-out
    step(1, 0, 0, 8'h11);
    check("after_first_write", uio_out, 8'h00);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    step(0, 1, 0, 8'h00); check("rd0", uo_out, 8'h11); check("rd0_st", uio_out, 8'h10);
    step(0, 1, 0, 8'h00); check("rd1", uo_out, 8'h22);
    step(0, 1, 0, 8'h00); check("rd2", uo_out, 8'h33); check("rd2_st", uio_out, 8'h50);
    step(0, 0, 0, 8'h00); check("drained", uio_out, 8'h40); check("hold_uo", uo_out, 8'h33);

    // Fill past capacity
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(i));
    check("full", uio_out, 8'h20);
    step(1, 0, 0, 8'h10);
    check("overflow", uio_out, 8'hA0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'h00);
      check($sformatf("drain%0d", i), uo_out, 8'(i));
    end
    check("drain_end", uio_out, 8'hD0);
    step(0, 0, 0, 8'h00); check("ovf_sticky", uio_out, 8'hC0);
    step(0, 0, 1, 8'h00); check("clear_ovf", uio_out, 8'h40);

    // Read+write on a full buffer, pointer wrap
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'h30 + 8'(i));
    step(1, 1, 0, 8'hAA);
    check("rw_full_uo", uo_out, 8'h30);
    check("rw_full_st", uio_out, 8'h30);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);
    check("wrap_last", uo_out, 8'hAA);
    check("wrap_empty", uio_out, 8'h50);

    // Empty read and no bypass
    step(0, 1, 0, 8'h00); check("empty_rd_uo", uo_out, 8'hAA); check("empty_rd_st", uio_out, 8'h40);
    step(1, 1, 0, 8'h55); check("nobypass_uo", uo_out, 8'hAA); check("nobypass_st", uio_out, 8'h00);
    step(0, 1, 0, 8'h00); check("late_rd", uo_out, 8'h55);

    // ena low holds everything
    step(1, 0, 0, 8'h01);
    step(1, 0, 0, 8'h02);
    step(0, 1, 0, 8'h00); check("pre_hold", uo_out, 8'h01);
    ena = 1'b0;
    step(1, 1, 0, 8'hFF); check("ena0_uo", uo_out, 8'h01); check("ena0_st", uio_out, 8'h10);
    step(0, 0, 1, 8'hFF); check("ena0_clr", uio_out, 8'h10);
    ena = 1'b1;
    step(0, 1, 0, 8'h00); check("post_hold", uo_out, 8'h02);

    // clear and reset mid-readout
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h70 + 8'(i));
    step(0, 1, 0, 8'h00); check("mid_rd", uo_out, 8'h70);
    step(1, 1, 1, 8'h99); check("clr_uo", uo_out, 8'h00); check("clr_st", uio_out, 8'h40);
    step(1, 0, 0, 8'h81);
    step(1, 0, 0, 8'h82);
    step(0, 1, 0, 8'h00); check("mid_rd2", uo_out, 8'h81);
    rst = 1'b1;
    step(0, 1, 0, 8'h00); check("rst_uo", uo_out, 8'h00); check("rst_st", uio_out, 8'h40);
    rst = 1'b0;
    step(0, 1, 0, 8'h00); check("rst_empty_rd", uio_out, 8'h40);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
